vrbridge_pp: RTL and testbench
==============================

Name: vrbridge_pp

Overview:
- Parametrised successor to the team's VIP raw bridge.
- Strips Avalon-ST video control packets (type 0xF) and decodes them into width/height/interlace.
- Forwards video data packets (type 0x0) as raw pixel beats; discards all other packet types.
- Adds multi-pixel-per-beat support, atomic header commit, per-line end-of-line marking, and frame-size enforcement with short/long error flags.

Parameters:
- COLOR_BITS, 8, bits per colour symbol; must be ≥4.
- COLOR_PLANES, 3, symbols per pixel, 1..4.
- PIXELS_IN_PARALLEL, 1, pixels per beat, 1..4.
- DATA_WIDTH, 24, must equal COLOR_BITS*COLOR_PLANES*PIXELS_IN_PARALLEL.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- din_data  in  DATA_WIDTH  input beat
- din_valid  in  1  input valid
- din_ready  out  1  input ready
- din_startofpacket  in  1  input SOP
- din_endofpacket  in  1  input EOP
- dout_data  out  DATA_WIDTH  pixel beat, equals din_data
- dout_valid  out  1  output valid
- dout_ready  in  1  downstream ready
- dout_startofpacket  out  1  first pixel beat of frame
- dout_endofpacket  out  1  last pixel beat of frame
- dout_eol  out  1  last beat of a line
- im_width  out  16  committed width
- im_height  out  16  committed height
- im_interlaced  out  4  committed interlace nibble
- im_valid  out  1  at least one complete control packet has been committed
- err_short  out  1  one-cycle pulse: data EOP before expected frame end
- err_long  out  1  one-cycle pulse: frame longer than expected

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, all im_* = 0, im_valid = 0, err_* = 0, counters = 0.
- Beat acceptance: a beat is accepted when din_valid & din_ready.
- Ready: din_ready = dout_ready in DATA; din_ready = 1 in every other state.
- Output data path: dout_valid = din_valid in DATA, else 0. Data path is combinational, zero latency. SOP, EOP and EOL are all qualified by dout_valid.
- States: IDLE, HEAD, DATA, DROP.
- IDLE: an accepted SOP beat decodes din_data[3:0]:
  - 0xF → HEAD
  - 0x0 → DATA
  - any other value → DROP
  - A SOP beat carrying EOP returns to IDLE.
  - Non-SOP beats are consumed and ignored.
- HEAD: nibble collector.
  - Each accepted beat contributes nibbles of symbols 0..COLOR_PLANES*PIXELS_IN_PARALLEL-1, in order; symbol k occupies bits [k*COLOR_BITS+3 : k*COLOR_BITS].
  - Nibbles 0-3: width, MSB first. Nibbles 4-7: height. Nibble 8: interlaced. Nibbles 9+ are ignored.
  - At accepted EOP: if ≥9 nibbles were collected, commit all three fields together and set im_valid = 1. Otherwise keep the previous values. Then go to IDLE.
- DATA line/frame counters:
  - Beats per line: B = ceil(im_width / PIXELS_IN_PARALLEL).
  - Lines per frame: L = im_height when im_interlaced[3] = 0. When im_interlaced[3] = 1, L = (im_height >> 1) + (im_height[0] & ~im_interlaced[2]).
  - x counts 0..B-1, y counts 0..L-1, advancing on accepted beats.
  - dout_startofpacket is asserted on the first beat in DATA.
  - dout_eol is asserted when x = B-1.
- DATA frame-end rules:
  - din EOP at x = B-1, y = L-1: normal end; dout_endofpacket = 1; go to IDLE.
  - din EOP earlier than that: pass EOP through, pulse err_short, go to IDLE.
  - Frame end reached without din EOP: force dout_endofpacket on that beat, pulse err_long, go to DROP.
- Unchecked mode: if im_valid = 0, or im_width = 0, or L = 0, DATA is pure pass-through. dout_eol stays 0, no error checks, end only on din EOP.
- DROP: consume beats until an accepted EOP, then go to IDLE.
- Resync: an accepted SOP in HEAD, DATA or DROP restarts type decode as if in IDLE.
  - In DATA with checking active, this also pulses err_short.
  - In HEAD, the partial header is discarded.
- Simultaneous events: a commit in HEAD and a new SOP cannot share a cycle. A single-beat data packet (SOP+EOP) emits SOP and EOP on the same beat.
- Header registers change only at commit, never mid-frame.

Optional Feature:
- Macro: VRB_STATUS_EN.
- When defined, adds output ports:
  - frame_cnt [15:0]: wraps; counts completed data packets.
  - err_cnt [7:0]: saturates at 255; counts err_short and err_long pulses.
  - Both reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package vrbridge_pkg: state encodings, packet type constants (CTRL = 4'hF, VIDEO = 4'h0), header nibble count (9), field-width constants.
- Sub-module vrbridge_hdr_parse: nibble collector, shadow registers and atomic commit. Its inputs are the beat, the accept strobe and the EOP; its outputs are the im_* signals and im_valid.

Test Plan:
- COLOR_PLANES=3, PIXELS_IN_PARALLEL=1. Control packet encoding width 640, height 480, interlace 0 → im_width = 640, im_height = 480, im_interlaced = 0, im_valid = 1, all after EOP.
- COLOR_PLANES=1, PIXELS_IN_PARALLEL=2, width 4, height 2. Data packet of 4 beats → dout_eol on beats 2 and 4, dout_endofpacket on beat 4, no errors.
- width 4, height 2, PIXELS_IN_PARALLEL=1. Data EOP on beat 5 → EOP passed on beat 5, err_short pulse.
- Same geometry, 10-beat data packet → forced dout_endofpacket on beat 8, err_long pulse, beats 9-10 dropped with din_ready = 1.
- Control packet truncated after 5 nibbles → im_* unchanged. Type 0x3 packet → fully consumed, dout_valid = 0 throughout.
- dout_ready held low for 3 cycles mid-line → din_ready = 0 and counters hold. Assert rst_n low mid-frame → state IDLE, im_valid = 0.

Source files
------------

// File: rtl/vrbridge_pkg.sv
// Shared types and constants for the vrbridge_pp video raw bridge.
package vrbridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_DATA,
        ST_DROP
    } state_e;

    localparam logic [3:0] PKT_CTRL  = 4'hF;
    localparam logic [3:0] PKT_VIDEO = 4'h0;

    localparam int HDR_NIBBLES = 9;
    localparam int NIB_W       = 4;
    localparam int HDR_BITS    = HDR_NIBBLES * NIB_W;
    localparam int DIM_W       = 16;
    localparam int IL_W        = 4;

    function automatic state_e decode_type(input logic [3:0] pkt_type);
        case (pkt_type)
            PKT_CTRL:  return ST_HEAD;
            PKT_VIDEO: return ST_DATA;
            default:   return ST_DROP;
        endcase
    endfunction

endpackage

// File: rtl/vrbridge_hdr_parse.sv
// Control-packet nibble collector; width/height/interlace are committed
// together only when a packet ends with at least HDR_NIBBLES nibbles.
module vrbridge_hdr_parse
    import vrbridge_pkg::*;
#(
    parameter int COLOR_BITS         = 8,
    parameter int COLOR_PLANES       = 3,
    parameter int PIXELS_IN_PARALLEL = 1,
    parameter int DATA_WIDTH         = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] beat_i,
    input  logic                  accept_i,
    input  logic                  clear_i,
    input  logic                  eop_i,
    output logic [DIM_W-1:0]      im_width_o,
    output logic [DIM_W-1:0]      im_height_o,
    output logic [IL_W-1:0]       im_interlaced_o,
    output logic                  im_valid_o
);

    localparam int NSYM = COLOR_PLANES * PIXELS_IN_PARALLEL;

    logic [NSYM*NIB_W-1:0] beat_nib;
    logic [HDR_BITS-1:0]   hdr_q, hdr_d;
    logic [4:0]            cnt_q, cnt_d;
    logic                  commit;
    logic [DIM_W-1:0]      width_q, height_q;
    logic [IL_W-1:0]       il_q;
    logic                  valid_q;
    logic                  unused_beat;

    assign unused_beat = ^beat_i;

    always_comb begin
        beat_nib = '0;
        for (int k = 0; k < NSYM; k++) begin
            beat_nib[k*NIB_W +: NIB_W] = beat_i[k*COLOR_BITS +: NIB_W];
        end
    end

    // Nibble n of the header lands in hdr[n*4 +: 4]; count saturates at HDR_NIBBLES.
    always_comb begin
        hdr_d  = hdr_q;
        cnt_d  = cnt_q;
        commit = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (accept_i) begin
            for (int n = 0; n < HDR_NIBBLES; n++) begin
                for (int k = 0; k < NSYM; k++) begin
                    if (int'(cnt_q) + k == n) begin
                        hdr_d[n*NIB_W +: NIB_W] = beat_nib[k*NIB_W +: NIB_W];
                    end
                end
            end
            if (int'(cnt_q) + NSYM >= HDR_NIBBLES) begin
                cnt_d = 5'(HDR_NIBBLES);
            end else begin
                cnt_d = cnt_q + 5'(NSYM);
            end
            if (eop_i) begin
                commit = (cnt_d == 5'(HDR_NIBBLES));
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        hdr_q <= hdr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
            il_q     <= '0;
            valid_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (commit) begin
                width_q  <= {hdr_d[3:0],   hdr_d[7:4],   hdr_d[11:8],  hdr_d[15:12]};
                height_q <= {hdr_d[19:16], hdr_d[23:20], hdr_d[27:24], hdr_d[31:28]};
                il_q     <= hdr_d[35:32];
                valid_q  <= 1'b1;
            end
        end
    end

    assign im_width_o      = width_q;
    assign im_height_o     = height_q;
    assign im_interlaced_o = il_q;
    assign im_valid_o      = valid_q;

endmodule

// File: rtl/vrbridge_pp.sv
// Avalon-ST video bridge: strips control packets, forwards video beats with
// line/frame marking and size enforcement. Optional macro: VRB_STATUS_EN.
module vrbridge_pp
    import vrbridge_pkg::*;
#(
    parameter int COLOR_BITS         = 8,
    parameter int COLOR_PLANES       = 3,
    parameter int PIXELS_IN_PARALLEL = 1,
    parameter int DATA_WIDTH         = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  din_startofpacket,
    input  logic                  din_endofpacket,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    output logic                  dout_eol,
    output logic [DIM_W-1:0]      im_width,
    output logic [DIM_W-1:0]      im_height,
    output logic [IL_W-1:0]       im_interlaced,
    output logic                  im_valid,
    output logic                  err_short,
    output logic                  err_long
`ifdef VRB_STATUS_EN
    ,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            err_cnt
`endif
);

    localparam logic [DIM_W:0] PIX_STEP = (DIM_W+1)'(PIXELS_IN_PARALLEL);

    state_e           state_q, state_d;
    logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
    logic             first_q, first_d;
    logic             err_short_q, err_short_d, err_long_q, err_long_d;
    logic             acc, in_data, chk, x_last, y_last, f_last;
    logic [DIM_W-1:0] lines;
    logic [DIM_W:0]   x_next;

    vrbridge_hdr_parse #(
        .COLOR_BITS         (COLOR_BITS),
        .COLOR_PLANES       (COLOR_PLANES),
        .PIXELS_IN_PARALLEL (PIXELS_IN_PARALLEL),
        .DATA_WIDTH         (DATA_WIDTH)
    ) u_hdr (
        .clk             (clk),
        .rst_n           (rst_n),
        .beat_i          (din_data),
        .accept_i        (acc & (state_q == ST_HEAD) & ~din_startofpacket),
        .clear_i         (acc & din_startofpacket),
        .eop_i           (din_endofpacket),
        .im_width_o      (im_width),
        .im_height_o     (im_height),
        .im_interlaced_o (im_interlaced),
        .im_valid_o      (im_valid)
    );

    assign in_data   = (state_q == ST_DATA);
    assign din_ready = in_data ? dout_ready : 1'b1;
    assign acc       = din_valid & din_ready;

    // Interlaced frames carry one field: half the lines, odd line to field F0 only.
    assign lines = im_interlaced[3]
                 ? ((im_height >> 1) + {{(DIM_W-1){1'b0}}, im_height[0] & ~im_interlaced[2]})
                 : im_height;
    assign chk   = im_valid & (im_width != '0) & (lines != '0);

    // x counts pixels in steps of PIXELS_IN_PARALLEL, so a partial last beat still ends the line.
    assign x_next = {1'b0, x_q} + PIX_STEP;
    assign x_last = (x_next >= {1'b0, im_width});
    assign y_last = (({1'b0, y_q} + (DIM_W+1)'(1)) == {1'b0, lines});
    assign f_last = chk & x_last & y_last;

    assign dout_data          = din_data;
    assign dout_valid         = in_data & din_valid;
    assign dout_startofpacket = dout_valid & first_q;
    assign dout_eol           = dout_valid & chk & x_last;
    assign dout_endofpacket   = dout_valid & (din_endofpacket | f_last);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        first_d     = first_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        if (acc) begin
            if (din_startofpacket) begin
                state_d     = din_endofpacket ? ST_IDLE : decode_type(din_data[3:0]);
                x_d         = '0;
                y_d         = '0;
                first_d     = 1'b1;
                err_short_d = in_data & chk;
            end else begin
                case (state_q)
                    ST_HEAD, ST_DROP: begin
                        if (din_endofpacket) state_d = ST_IDLE;
                    end
                    ST_DATA: begin
                        first_d = 1'b0;
                        if (din_endofpacket) begin
                            state_d     = ST_IDLE;
                            err_short_d = chk & ~f_last;
                        end else if (f_last) begin
                            state_d    = ST_DROP;
                            err_long_d = 1'b1;
                        end else if (chk) begin
                            if (x_last) begin
                                x_d = '0;
                                y_d = y_q + DIM_W'(1);
                            end else begin
                                x_d = x_next[DIM_W-1:0];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            first_q     <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            first_q     <= first_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign err_short = err_short_q;
    assign err_long  = err_long_q;

`ifdef VRB_STATUS_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (acc & in_data & ~din_startofpacket & dout_endofpacket) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if ((err_short_q | err_long_q) && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_vrbridge_pp.sv
// Bench for vrbridge_pp (1 plane, 2 pixels per beat): geometry table,
// directed corner sequences and randomized packets against a packet-level model.
module tb_vrbridge_pp;

    localparam int CB   = 8;
    localparam int CP   = 1;
    localparam int PP   = 2;
    localparam int DW   = 16;
    localparam int NSYM = CP * PP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din_data = '0;
    logic          din_valid = 1'b0, din_ready;
    logic          din_startofpacket = 1'b0, din_endofpacket = 1'b0;
    logic [DW-1:0] dout_data;
    logic          dout_valid, dout_ready = 1'b0;
    logic          dout_startofpacket, dout_endofpacket, dout_eol;
    logic [15:0]   im_width, im_height;
    logic [3:0]    im_interlaced;
    logic          im_valid, err_short, err_long;

    always #5 clk = ~clk;

    vrbridge_pp #(
        .COLOR_BITS(CB), .COLOR_PLANES(CP), .PIXELS_IN_PARALLEL(PP), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
        .din_startofpacket(din_startofpacket), .din_endofpacket(din_endofpacket),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
        .dout_eol(dout_eol),
        .im_width(im_width), .im_height(im_height), .im_interlaced(im_interlaced),
        .im_valid(im_valid), .err_short(err_short), .err_long(err_long)
    );

    int errors = 0;
    int checks = 0;

    // Reference header state and pending error pulses
    logic [15:0] m_w = '0, m_h = '0;
    logic [3:0]  m_il = '0;
    logic        m_v = 1'b0;
    bit pend_es = 0, pend_el = 0;
    bit rand_en = 0, mdl_en = 1;
    int stall_cnt = 0, stall_idx = -1;

    int obs_fwd, obs_eol, obs_eop_idx, obs_short, obs_long, obs_nready;

    typedef struct {
        int w; int h; int il; int n;
        int fwd; int eol; int eop; int es; int el;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_obs();
        obs_fwd = 0; obs_eol = 0; obs_eop_idx = -1;
        obs_short = 0; obs_long = 0; obs_nready = 0;
    endtask

    task automatic geom(output bit c, output int b, output int t);
        int l;
        l = m_il[3] ? (int'(m_h >> 1) + int'(m_h[0] & ~m_il[2])) : int'(m_h);
        b = (int'(m_w) + PP - 1) / PP;
        t = b * l;
        c = m_v && (m_w != 0) && (l != 0);
    endtask

    task automatic cycle(input logic [DW-1:0] d, input bit sop, input bit eop, input bit want,
                         input bit fwd, input bit e_sop, input bit e_eol, input bit e_eop,
                         output bit acc);
        @(negedge clk);
        din_data = d;
        din_startofpacket = sop;
        din_endofpacket = eop;
        din_valid = want && (!rand_en || $urandom_range(3) != 0);
        if (stall_cnt > 0) begin
            dout_ready = 1'b0;
            stall_cnt--;
        end else begin
            dout_ready = !rand_en || $urandom_range(3) != 0;
        end
        #1;
        acc = din_valid & din_ready;
        if (!din_ready) obs_nready++;
        if (err_short) obs_short++;
        if (err_long) obs_long++;
        if (dout_valid && dout_ready) begin
            if (dout_eol) obs_eol++;
            if (dout_endofpacket) obs_eop_idx = obs_fwd;
            obs_fwd++;
        end
        if (mdl_en) begin
            check("err_short", err_short, pend_es);
            check("err_long", err_long, pend_el);
            check("im_width", im_width, m_w);
            check("im_height", im_height, m_h);
            check("im_interlaced", im_interlaced, m_il);
            check("im_valid", im_valid, m_v);
            check("din_ready", din_ready, fwd ? dout_ready : 1'b1);
            check("dout_valid", dout_valid, fwd & din_valid);
            if (fwd && din_valid) begin
                check("dout_data", dout_data, d);
                check("dout_sop", dout_startofpacket, e_sop);
                check("dout_eol", dout_eol, e_eol);
                check("dout_eop", dout_endofpacket, e_eop);
            end
        end
        pend_es = 0;
        pend_el = 0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit sop, input bit eop, input bit fwd,
                             input bit e_sop, input bit e_eol, input bit e_eop);
        bit acc;
        int tries = 0;
        do begin
            cycle(d, sop, eop, 1'b1, fwd, e_sop, e_eol, e_eop, acc);
            tries++;
        end while (!acc && tries < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: beat not accepted after %0d cycles", tries);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle('0, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    task automatic send_pkt(input logic [3:0] typ, input logic [DW-1:0] body[$]);
        int n, b, t;
        bit c, fwd;
        logic [DW-1:0] hb;
        logic [3:0] nibs[$];
        n = body.size();
        geom(c, b, t);
        hb = DW'($urandom);
        hb[3:0] = typ;
        send_beat(hb, 1'b1, n == 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == stall_idx) stall_cnt = 3;
            fwd = (typ == 4'h0) && (!c || i < t);
            send_beat(body[i], 1'b0, i == n - 1, fwd, i == 0,
                      c && (i % b == b - 1), (i == n - 1) || (c && i == t - 1));
            if (typ == 4'h0 && c) begin
                if (i == t - 1 && n > t) pend_el = 1;
                if (i == n - 1 && n < t) pend_es = 1;
            end
            if (typ == 4'hF) begin
                for (int k = 0; k < NSYM; k++) nibs.push_back(body[i][k*CB +: 4]);
            end
        end
        if (typ == 4'hF && nibs.size() >= 9) begin
            m_w  = {nibs[0], nibs[1], nibs[2], nibs[3]};
            m_h  = {nibs[4], nibs[5], nibs[6], nibs[7]};
            m_il = nibs[8];
            m_v  = 1'b1;
        end
    endtask

    task automatic send_hdr(input int w, input int h, input int il, input int nb);
        logic [3:0] nib[10];
        logic [DW-1:0] q[$];
        logic [DW-1:0] bt;
        logic [15:0] w16, h16;
        w16 = 16'(w);
        h16 = 16'(h);
        nib = '{w16[15:12], w16[11:8], w16[7:4], w16[3:0],
                h16[15:12], h16[11:8], h16[7:4], h16[3:0], 4'(il), 4'($urandom)};
        for (int j = 0; j < nb; j++) begin
            bt = DW'($urandom);
            bt[3:0]  = nib[2*j];
            bt[11:8] = nib[2*j+1];
            q.push_back(bt);
        end
        send_pkt(4'hF, q);
    endtask

    task automatic send_body(input logic [3:0] typ, input int n);
        logic [DW-1:0] q[$];
        for (int j = 0; j < n; j++) q.push_back(DW'($urandom));
        send_pkt(typ, q);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit c, acc;
        int b, t, r, n;
        logic [DW-1:0] hb;

        tbl[0] = '{4, 2, 0,  4,  4, 2, 3, 0, 0};
        tbl[1] = '{8, 2, 0,  5,  5, 1, 4, 1, 0};
        tbl[2] = '{8, 2, 0, 10,  8, 2, 7, 0, 1};
        tbl[3] = '{5, 3, 0,  9,  9, 3, 8, 0, 0};
        tbl[4] = '{4, 5, 8,  6,  6, 3, 5, 0, 0};
        tbl[5] = '{4, 5, 12, 4,  4, 2, 3, 0, 0};
        tbl[6] = '{0, 2, 0,  3,  3, 0, 2, 0, 0};
        tbl[7] = '{3, 1, 0,  1,  1, 0, 0, 1, 0};
        tbl[8] = '{2, 1, 0,  1,  1, 1, 0, 0, 0};
        tbl[9] = '{4, 4, 8,  6,  4, 2, 3, 0, 1};

        // Reset state
        din_valid = 1'b1;
        dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_im_valid", im_valid, 0);
        check("rst_im_width", im_width, 0);
        check("rst_err_short", err_short, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_din_ready", din_ready, 1);
        din_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            send_hdr(tbl[i].w, tbl[i].h, tbl[i].il, 5);
            idle(1);
            clr_obs();
            send_body(4'h0, tbl[i].n);
            idle(2);
            check("tbl_fwd", obs_fwd, tbl[i].fwd);
            check("tbl_eol", obs_eol, tbl[i].eol);
            check("tbl_eop_idx", obs_eop_idx, tbl[i].eop);
            check("tbl_short", obs_short, tbl[i].es);
            check("tbl_long", obs_long, tbl[i].el);
        end

        send_hdr(640, 480, 0, 5);
        idle(1);
        check("hdr640_w", im_width, 640);
        check("hdr640_h", im_height, 480);
        check("hdr640_il", im_interlaced, 0);
        check("hdr640_v", im_valid, 1);

        send_hdr(100, 100, 3, 3);
        idle(1);
        check("trunc_w", im_width, 640);
        check("trunc_h", im_height, 480);

        clr_obs();
        send_body(4'h3, 4);
        idle(1);
        check("type3_fwd", obs_fwd, 0);

        // Back-pressure mid-line
        send_hdr(8, 2, 0, 5);
        idle(1);
        clr_obs();
        stall_idx = 2;
        send_body(4'h0, 8);
        stall_idx = -1;
        idle(1);
        check("stall_nready", obs_nready, 3);
        check("stall_eol", obs_eol, 2);
        check("stall_eop_idx", obs_eop_idx, 7);

        // Resync: new SOP while a checked frame is in progress
        clr_obs();
        hb = DW'($urandom);
        hb[3:0] = 4'h0;
        send_beat(hb, 1, 0, 0, 0, 0, 0);
        send_beat(DW'($urandom), 0, 0, 1, 1, 0, 0);
        mdl_en = 0;
        hb[3:0] = 4'h3;
        send_beat(hb, 1, 0, 0, 0, 0, 0);
        send_beat(DW'($urandom), 0, 1, 0, 0, 0, 0);
        idle(2);
        mdl_en = 1;
        check("resync_short", obs_short, 1);
        check("resync_long", obs_long, 0);
        check("resync_w", im_width, 8);

        // Asynchronous reset in the middle of a frame
        hb[3:0] = 4'h0;
        send_beat(hb, 1, 0, 0, 0, 0, 0);
        send_beat(DW'($urandom), 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        din_valid = 1'b0;
        dout_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_im_valid", im_valid, 0);
        check("midrst_im_width", im_width, 0);
        check("midrst_din_ready", din_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        m_w = '0; m_h = '0; m_il = '0; m_v = 1'b0;
        pend_es = 0; pend_el = 0;
        cycle(DW'($urandom), 0, 0, 1, 0, 0, 0, 0, acc);

        // Randomized packets
        rand_en = 1;
        for (int p = 0; p < 70; p++) begin
            r = $urandom_range(9);
            if (r < 4) begin
                send_hdr($urandom_range(9), $urandom_range(5), $urandom_range(15), $urandom_range(6));
            end else if (r < 9) begin
                geom(c, b, t);
                n = c ? $urandom_range(t + 3) : $urandom_range(6);
                send_body(4'h0, n);
            end else begin
                send_body(4'($urandom_range(14, 1)), $urandom_range(4));
            end
            if ($urandom_range(1) == 1) idle($urandom_range(3, 1));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
